// File: rtl/counter_seq_ctrl.sv
// rtl/counter_seq_ctrl.sv - LOAD/START/STOP sequencer for the counter datapath with prescaled stepping.
// Optional periodic mode: define COUNTER_SEQ_CTRL_AUTORELOAD_EN.
module counter_seq_ctrl #(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 1
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic [1:0]       i_cmd_op,
    input  logic [WIDTH-1:0] i_cmd_data,
    input  logic [WIDTH-1:0] i_cnt_q,
    output logic             o_cnt_load,
    output logic [WIDTH-1:0] o_cnt_load_val,
    output logic             o_cnt_en,
    output logic             o_cnt_up,
    output logic             o_busy,
    output logic             o_done
);

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_UP   = 2'b01;
    localparam logic [1:0] OP_DOWN = 2'b10;
    localparam logic [1:0] OP_STOP = 2'b11;
    localparam logic [7:0] PRE_LAST = 8'(PRESCALE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_STEP,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_load_val;
    logic [WIDTH-1:0] r_term;
    logic             r_up;
    logic [7:0]       r_pre;

    logic w_cmd_ready;
    logic w_accept;
    logic w_stop;
    logic w_done_load;

    // Non-STOP ops are back-pressured while running so they are held, not dropped.
    always_comb begin
        w_cmd_ready = 1'b0;
        case (r_state)
            S_IDLE:         w_cmd_ready = 1'b1;
            S_RUN, S_STEP:  w_cmd_ready = (i_cmd_op == OP_STOP);
            default:        w_cmd_ready = 1'b0;
        endcase
    end

    assign w_accept = i_cmd_valid && w_cmd_ready;
    assign w_stop   = w_accept && (i_cmd_op == OP_STOP);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state    <= S_IDLE;
            r_load_val <= '0;
            r_term     <= '0;
            r_up       <= 1'b0;
            r_pre      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        case (i_cmd_op)
                            OP_LOAD: begin
                                r_load_val <= i_cmd_data;
                                r_state    <= S_LOAD;
                            end
                            OP_UP, OP_DOWN: begin
                                r_term     <= i_cmd_data;
                                r_up       <= i_cmd_op[0];
                                r_load_val <= i_cnt_q;
                                r_pre      <= '0;
                                r_state    <= S_RUN;
                            end
                            default: ;
                        endcase
                    end
                end
                S_LOAD: r_state <= S_IDLE;
                S_RUN: begin
                    if (w_stop) begin
                        r_state <= S_IDLE;
                    end else if (r_pre == PRE_LAST) begin
                        r_state <= (i_cnt_q == r_term) ? S_DONE : S_STEP;
                    end else begin
                        r_pre <= r_pre + 8'd1;
                    end
                end
                S_STEP: begin
                    if (w_stop) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_pre   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_DONE: begin
`ifdef COUNTER_SEQ_CTRL_AUTORELOAD_EN
                    r_pre   <= '0;
                    r_state <= S_RUN;
`else
                    r_state <= S_IDLE;
`endif
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef COUNTER_SEQ_CTRL_AUTORELOAD_EN
    assign w_done_load = (r_state == S_DONE);
`else
    assign w_done_load = 1'b0;
`endif

    assign o_cmd_ready    = w_cmd_ready;
    assign o_cnt_load     = (r_state == S_LOAD) || w_done_load;
    assign o_cnt_load_val = r_load_val;
    assign o_cnt_en       = (r_state == S_STEP);
    assign o_cnt_up       = r_up;
    assign o_busy         = (r_state != S_IDLE);
    assign o_done         = (r_state == S_DONE);

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// tb/tb_counter_seq_ctrl.sv - bench for counter_seq_ctrl with a modelled 4-bit counter and cycle-schedule model.
module tb_counter_seq_ctrl;

    localparam int W = 4;
    localparam int P = 1;
`ifdef COUNTER_SEQ_CTRL_AUTORELOAD_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         valid = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] data = '0;
    logic [W-1:0] q = '0;
    logic         cmd_ready, cnt_load, cnt_en, cnt_up, busy, done;
    logic [W-1:0] load_val;

    logic         q_wr = 1'b0;
    logic [W-1:0] q_wval = '0;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    int           m_mode = 0;
    int           m_t0 = 0;
    int           m_n = 0;
    logic [W-1:0] m_val = '0;
    logic         m_up = 1'b0;
    int           en_cnt = 0;
    int           done_rel = -1;

    counter_seq_ctrl #(.WIDTH(W), .PRESCALE(P)) dut (
        .i_clk(clk),
        .i_reset_n(rst_n),
        .i_cmd_valid(valid),
        .o_cmd_ready(cmd_ready),
        .i_cmd_op(op),
        .i_cmd_data(data),
        .i_cnt_q(q),
        .o_cnt_load(cnt_load),
        .o_cnt_load_val(load_val),
        .o_cnt_en(cnt_en),
        .o_cnt_up(cnt_up),
        .o_busy(busy),
        .o_done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (q_wr)          q <= q_wval;
        else if (cnt_load) q <= load_val;
        else if (cnt_en)   q <= cnt_up ? q + 4'd1 : q - 4'd1;
    end

    // Expected outputs follow from the schedule: step k at k*(P+1), done at N*(P+1)+P+1.
    always @(negedge clk) begin
        logic e_ready, e_load, e_en, e_busy, e_done;
        logic [W-1:0] diff;
        int rel, r, len;
        if (!rst_n) begin
            m_mode = 0;
            m_up   = 1'b0;
            m_val  = '0;
        end
        rel = cyc - m_t0;
        len = m_n * (P + 1) + P + 1;
        if (m_mode == 1 && rel >= 2) m_mode = 0;
        if (m_mode == 2 && !AR && rel > len) m_mode = 0;
        e_ready = 1'b1; e_load = 1'b0; e_en = 1'b0; e_busy = 1'b0; e_done = 1'b0;
        if (m_mode == 1) begin
            e_ready = 1'b0; e_load = 1'b1; e_busy = 1'b1;
        end else if (m_mode == 2) begin
            r = AR ? ((rel - 1) % len) + 1 : rel;
            e_busy  = 1'b1;
            e_en    = (r % (P + 1) == 0) && (r / (P + 1) >= 1) && (r / (P + 1) <= m_n);
            e_done  = (r == len);
            e_load  = AR && (r == len);
            e_ready = (op == 2'b11) && (r != len);
        end
        tests++;
        if ({cmd_ready, cnt_load, load_val, cnt_en, cnt_up, busy, done} !==
            {e_ready, e_load, m_val, e_en, m_up, e_busy, e_done}) begin
            fails++;
            $display("FAIL outputs cycle %0d got rdy=%b ld=%b val=%h en=%b up=%b busy=%b done=%b exp rdy=%b ld=%b val=%h en=%b up=%b busy=%b done=%b",
                     cyc, cmd_ready, cnt_load, load_val, cnt_en, cnt_up, busy, done,
                     e_ready, e_load, m_val, e_en, m_up, e_busy, e_done);
        end
        if (cnt_en) en_cnt++;
        if (done && done_rel < 0) done_rel = cyc - m_t0;
        if (rst_n && valid && e_ready) begin
            if (m_mode == 0) begin
                if (op == 2'b00) begin
                    m_mode = 1; m_t0 = cyc; m_val = data;
                end else if (op != 2'b11) begin
                    diff   = op[0] ? data - q : q - data;
                    m_mode = 2; m_t0 = cyc; m_val = q; m_up = op[0];
                    m_n    = int'(diff);
                    en_cnt = 0; done_rel = -1;
                end
            end else if (m_mode == 2) begin
                m_mode = 0;
            end
        end
    end

    task automatic check(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] o, input logic [W-1:0] d);
        valid = 1'b1; op = o; data = d;
        tick();
        valid = 1'b0;
    endtask

    task automatic set_q(input logic [W-1:0] v);
        q_wr = 1'b1; q_wval = v;
        tick();
        q_wr = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            tick();
            if (done) seen = 1'b1;
        end
        check({name, "_done_seen"}, int'(seen), 1);
    endtask

    // STOP held two cycles: ignored harmlessly in IDLE, or taken in the RUN after a periodic DONE.
    task automatic finish_run();
        valid = 1'b1; op = 2'b11;
        tick();
        tick();
        valid = 1'b0;
        tick();
    endtask

    task automatic run_case(input string name, input logic [1:0] o, input logic [W-1:0] start,
                            input logic [W-1:0] term, input int exp_steps, input int exp_done);
        set_q(start);
        send(o, term);
        wait_done(name);
        finish_run();
        check({name, "_done_cycle"}, done_rel, exp_done);
        check({name, "_steps"}, en_cnt, exp_steps);
        check({name, "_final_q"}, int'(q), AR ? int'(start) : int'(term));
        check({name, "_idle"}, int'(busy), 0);
    endtask

    initial begin
        logic [W-1:0] qs;
        int n;
        bit got;
        tick();
        tick();
        check("ready_in_reset", int'(cmd_ready), 1);
        rst_n = 1'b1;
        tick();
        check("ready_after_reset", int'(cmd_ready), 1);
        check("busy_after_reset", int'(busy), 0);

        send(2'b00, 4'h9);
        check("load_pulse", int'(cnt_load), 1);
        check("load_val", int'(load_val), 9);
        tick();
        check("load_idle_c2", int'(busy), 0);
        check("load_q", int'(q), 9);

        run_case("up_2_5", 2'b01, 4'h2, 4'h5, 3, 8);
        run_case("down_2_e", 2'b10, 4'h2, 4'hE, 4, 10);
        run_case("equal_7", 2'b01, 4'h7, 4'h7, 0, 2);
        run_case("up_e_1_wrap", 2'b01, 4'hE, 4'h1, 3, 8);

        set_q(4'h0);
        send(2'b01, 4'hF);
        valid = 1'b1; op = 2'b00; data = 4'h3;
        tick(); tick(); tick();
        check("load_held_ready", int'(cmd_ready), 0);
        check("load_held_busy", int'(busy), 1);
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            tick();
            if (cnt_en) got = 1'b1;
        end
        check("step_seen", int'(got), 1);
        qs = q;
        op = 2'b11;
        #1;
        check("stop_ready_in_step", int'(cmd_ready), 1);
        tick();
        valid = 1'b0;
        check("stop_idle", int'(busy), 0);
        check("stop_step_completed", int'(q), int'(qs + 4'd1));
        tick();

        set_q(4'h0);
        send(2'b10, 4'h5);
        repeat (5) tick();
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_outs", int'({cnt_en, cnt_load, done, cnt_up}), 0);
        check("async_rst_val", int'(load_val), 0);
        check("async_rst_ready", int'(cmd_ready), 1);
        tick();
        rst_n = 1'b1;
        tick();

`ifdef COUNTER_SEQ_CTRL_AUTORELOAD_EN
        set_q(4'h3);
        send(2'b01, 4'h5);
        wait_done("periodic");
        check("periodic_load", int'(cnt_load), 1);
        check("periodic_val", int'(load_val), 3);
        for (int k = 0; k < 2; k++) begin
            n = 0;
            got = 1'b0;
            for (int i = 0; i < 20 && !got; i++) begin
                tick();
                n++;
                if (done) got = 1'b1;
            end
            check("periodic_period", n, 6);
            check("periodic_reload", int'({cnt_load, load_val}), int'({1'b1, 4'h3}));
        end
        finish_run();
        check("periodic_stopped", int'(busy), 0);
`endif

        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
